// File: rtl/lock_key_sequencer_if.sv
// Control/lock-side signal bundle for lock_key_sequencer.
// The slave modport is the sequencer; the master modport is the controller plus the lock.
interface lock_key_sequencer_if #(
    parameter int NUM_SYM = 6
);
    logic                   start;
    logic                   abort;
    logic [2*NUM_SYM-1:0]   key_in;
    logic                   unlock;
    logic                   inp0;
    logic                   inp1;
    logic                   busy;
    logic                   done;
    logic                   success;
    logic [3:0]             tries;

    modport slave (
        input  start, abort, key_in, unlock,
        output inp0, inp1, busy, done, success, tries
    );

    modport master (
        output start, abort, key_in, unlock,
        input  inp0, inp1, busy, done, success, tries
    );
endinterface

// File: rtl/lock_key_sequencer.sv
// Sends a latched key as 2-bit symbols on inp0/inp1, watches unlock, and reports the outcome.
// Define LOCK_SEQ_RETRY_EN to enable the WAIT->GAP->SEND retry path (up to MAX_TRIES attempts).
module lock_key_sequencer #(
    parameter int NUM_SYM   = 6,
    parameter int WAIT_CYC  = 4,
    parameter int GAP_CYC   = 2,
    parameter int MAX_TRIES = 3
) (
    input  logic                clk,
    input  logic                rst,
    lock_key_sequencer_if.slave bus
);
    localparam int KEY_W     = 2 * NUM_SYM;
    localparam int SYM_W     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int WAIT_LEN  = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
    localparam int GAP_LEN   = (GAP_CYC < 1) ? 1 : GAP_CYC;
    // WAIT and GAP never overlap, so they share one cycle counter.
    localparam int CNT_MAX   = (WAIT_LEN > GAP_LEN) ? WAIT_LEN : GAP_LEN;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TRIES_CFG = (MAX_TRIES < 1) ? 1 : ((MAX_TRIES > 15) ? 15 : MAX_TRIES);
`ifdef LOCK_SEQ_RETRY_EN
    localparam bit RETRY_ON  = 1'b1;
`else
    localparam bit RETRY_ON  = 1'b0;
`endif
    localparam logic [3:0] TRY_LIMIT = RETRY_ON ? 4'(TRIES_CFG) : 4'd1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_reg;
    logic [KEY_W-1:0] key_reg;
    logic [SYM_W-1:0] sym_cnt_reg;
    logic [SYM_W-1:0] sym_next;
    logic [CNT_W-1:0] cyc_cnt_reg;
    logic [1:0]       inp_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             success_reg;
    logic [3:0]       tries_reg;
    logic [1:0]       sym_arr [NUM_SYM];

    // Symbol k is the k-th bit pair counted from the MSB end of the latched key.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym
            assign sym_arr[gi] = key_reg[KEY_W-1-2*gi -: 2];
        end
    endgenerate

    assign sym_next = sym_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            key_reg     <= '0;
            sym_cnt_reg <= '0;
            cyc_cnt_reg <= '0;
            inp_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            success_reg <= 1'b0;
            tries_reg   <= 4'd0;
        end else if (bus.abort) begin
            // success and tries deliberately keep the result of the interrupted run.
            state_reg   <= S_IDLE;
            sym_cnt_reg <= '0;
            cyc_cnt_reg <= '0;
            inp_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        key_reg     <= bus.key_in;
                        tries_reg   <= 4'd1;
                        success_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        sym_cnt_reg <= '0;
                        inp_reg     <= bus.key_in[KEY_W-1 -: 2];
                        state_reg   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sym_cnt_reg == SYM_W'(NUM_SYM - 1)) begin
                        inp_reg     <= 2'b00;
                        cyc_cnt_reg <= '0;
                        state_reg   <= S_WAIT;
                    end else begin
                        sym_cnt_reg <= sym_next;
                        inp_reg     <= sym_arr[sym_next];
                    end
                end
                S_WAIT: begin
                    // unlock takes priority, so an unlock on the timeout edge still succeeds.
                    if (bus.unlock) begin
                        success_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= S_DONE;
                    end else if (cyc_cnt_reg == CNT_W'(WAIT_LEN - 1)) begin
                        cyc_cnt_reg <= '0;
                        if (tries_reg < TRY_LIMIT) begin
                            state_reg <= S_GAP;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end
`ifdef LOCK_SEQ_RETRY_EN
                S_GAP: begin
                    if (cyc_cnt_reg == CNT_W'(GAP_LEN - 1)) begin
                        cyc_cnt_reg <= '0;
                        sym_cnt_reg <= '0;
                        tries_reg   <= tries_reg + 4'd1;
                        inp_reg     <= sym_arr[0];
                        state_reg   <= S_SEND;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    inp_reg   <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.inp0    = inp_reg[1];
    assign bus.inp1    = inp_reg[0];
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.success = success_reg;
    assign bus.tries   = tries_reg;
endmodule
